booth_action_sequencer: RTL and testbench

//  Sequential radix-4 Booth recoder; source side of the action-code interface that feeds the partial-product selector.

---
 rtl/booth_pkg.sv | 23 ++
 rtl/booth_digit_encode.sv | 25 ++
 rtl/booth_action_sequencer.sv | 102 ++++++++++
 tb/tb_booth_action_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// booth_pkg : shared Booth action codes and sequencer state encoding
// Revision  : 1.0
// ============================================================================
package booth_pkg;

  localparam logic [2:0] ACT_ZERO = 3'd0;
  localparam logic [2:0] ACT_POS1 = 3'd1;
  localparam logic [2:0] ACT_POS2 = 3'd2;
  localparam logic [2:0] ACT_NEG1 = 3'd3;
  localparam logic [2:0] ACT_NEG2 = 3'd4;
  localparam logic [2:0] ACT_RSVD = 3'd7;

  // Shared with the accumulator controller; keep the encoding stable.
  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_EMIT = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/booth_digit_encode.sv
`default_nettype none
// ============================================================================
// booth_digit_encode : radix-4 Booth triplet {b[2k+1],b[2k],b[2k-1]} to action
// Revision           : 1.0
// ============================================================================
module booth_digit_encode
  import booth_pkg::*;
(
  input  logic [2:0] triplet,
  output logic [2:0] action
);

  always_comb begin
    action = ACT_ZERO;
    case (triplet)
      3'b001, 3'b010: action = ACT_POS1;
      3'b011:         action = ACT_POS2;
      3'b100:         action = ACT_NEG2;
      3'b101, 3'b110: action = ACT_NEG1;
      default:        action = ACT_ZERO;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/booth_action_sequencer.sv
`default_nettype none
// ============================================================================
// booth_action_sequencer : sequential radix-4 Booth recoder, one action/digit
// Revision               : 1.0
// ============================================================================
module booth_action_sequencer
  import booth_pkg::*;
#(
  parameter  int WIDTH  = 8,
  localparam int DIGITS = WIDTH / 2,
  localparam int IDXW   = $clog2(DIGITS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [WIDTH-1:0] multiplier,
  input  logic            flush,
  output logic [2:0]      action,
  output logic            action_valid,
  input  logic            action_ready,
  output logic [IDXW-1:0] digit_idx,
  output logic            last,
  output logic            done
);

  localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(DIGITS - 1);

  seq_state_t       r_state, w_state_nxt;
  logic [WIDTH:0]   r_shreg, w_shreg_nxt;
  logic [IDXW-1:0]  r_idx, w_idx_nxt;
  logic [2:0]       w_code;
  logic             w_at_last;

  booth_digit_encode u_encode (
    .triplet (r_shreg[2:0]),
    .action  (w_code)
  );

  assign w_at_last = (r_idx == C_LAST_IDX);
  assign digit_idx = r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEQ_IDLE;
      r_shreg <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_idx_nxt    = r_idx;
    start_ready  = 1'b0;
    action_valid = 1'b0;
    done         = 1'b0;

    case (r_state)
      SEQ_IDLE: start_ready = 1'b1;
      SEQ_EMIT: begin
        action_valid = 1'b1;
        if (action_ready) begin
          if (w_at_last) begin
            w_state_nxt = SEQ_DONE;
          end else begin
            w_shreg_nxt = {{2{r_shreg[WIDTH]}}, r_shreg[WIDTH:2]};
            w_idx_nxt   = r_idx + IDXW'(1);
          end
        end
      end
      SEQ_DONE: begin
        done        = 1'b1;
        start_ready = 1'b1;
        w_state_nxt = SEQ_IDLE;
      end
      default: w_state_nxt = SEQ_IDLE;
    endcase

    // A start in DONE overrides the return to IDLE so operands can stream.
    if (start_ready && start_valid) begin
      w_state_nxt = SEQ_EMIT;
      w_shreg_nxt = {multiplier, 1'b0};
      w_idx_nxt   = '0;
    end

    if (flush) begin
      w_state_nxt = SEQ_IDLE;
      w_shreg_nxt = r_shreg;
      w_idx_nxt   = r_idx;
    end

    action = action_valid ? w_code : ACT_ZERO;
    last   = action_valid && w_at_last;
  end

endmodule
`default_nettype wire

// File: tb/tb_booth_action_sequencer.sv
`default_nettype none
// ============================================================================
// tb_booth_action_sequencer : vectors, corner sequences and random ops vs model
// Revision                  : 1.0
// ============================================================================
module tb_booth_action_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_valid;
  logic       start_ready;
  logic [7:0] multiplier;
  logic       flush;
  logic [2:0] action;
  logic       action_valid;
  logic       action_ready;
  logic [1:0] digit_idx;
  logic       last;
  logic       done;

  int checks   = 0;
  int failures = 0;

  booth_action_sequencer #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .multiplier   (multiplier),
    .flush        (flush),
    .action       (action),
    .action_valid (action_valid),
    .action_ready (action_ready),
    .digit_idx    (digit_idx),
    .last         (last),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]      m;
    logic [3:0][2:0] codes;   // codes[k] is digit k
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: signed digit d_k = -2*b[2k+1] + b[2k] + b[2k-1], then map value to code.
  function automatic logic [3:0][2:0] model(input logic [7:0] m);
    logic [8:0]      b;
    logic [3:0][2:0] c;
    int              d;
    b = {m, 1'b0};
    for (int k = 0; k < 4; k++) begin
      d = -2 * int'(b[2*k+2]) + int'(b[2*k+1]) + int'(b[2*k]);
      case (d)
        1:       c[k] = 3'd1;
        2:       c[k] = 3'd2;
        -1:      c[k] = 3'd3;
        -2:      c[k] = 3'd4;
        default: c[k] = 3'd0;
      endcase
    end
    return c;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_action"}, action, 0);
    chk({tag, "_action_valid"}, action_valid, 0);
    chk({tag, "_digit_idx"}, digit_idx, 0);
    chk({tag, "_last"}, last, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_start_ready"}, start_ready, 1);
  endtask

  // Entered at a negedge where the sequencer should be ready; returns at the done negedge.
  task automatic run_op(input logic [7:0] m, input logic [3:0][2:0] exp,
                        input int stall_k, input int stall_n);
    chk("start_ready", start_ready, 1);
    start_valid  = 1'b1;
    multiplier   = m;
    action_ready = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    multiplier  = 8'($urandom);
    for (int k = 0; k < 4; k++) begin
      if (k == stall_k) begin
        action_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          chk("stall_valid", action_valid, 1);
          chk("stall_action", action, exp[k]);
          chk("stall_idx", digit_idx, k);
          @(negedge clk);
        end
        action_ready = 1'b1;
      end
      chk("valid", action_valid, 1);
      chk("action", action, exp[k]);
      chk("digit_idx", digit_idx, k);
      chk("last", last, (k == 3) ? 1 : 0);
      chk("done_early", done, 0);
      @(negedge clk);
    end
    chk("done_pulse", done, 1);
    chk("done_valid_low", action_valid, 0);
    chk("done_start_ready", start_ready, 1);
  endtask

  vec_t tbl[5];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][2:0] ec;
    int cnt, cyc;

    tbl[0] = '{8'h55, {3'd1, 3'd1, 3'd1, 3'd1}};
    tbl[1] = '{8'h7F, {3'd2, 3'd0, 3'd0, 3'd3}};
    tbl[2] = '{8'h80, {3'd4, 3'd0, 3'd0, 3'd0}};
    tbl[3] = '{8'h00, {3'd0, 3'd0, 3'd0, 3'd0}};
    tbl[4] = '{8'hFF, {3'd0, 3'd0, 3'd0, 3'd3}};

    rst = 1'b1; start_valid = 1'b0; multiplier = 8'h00; flush = 1'b0; action_ready = 1'b1;
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors, idle cycle between operands
    foreach (tbl[i]) begin
      run_op(tbl[i].m, tbl[i].codes, -1, 0);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
    end

    // Stall on digit 1 of 7F, then back-to-back FF started during DONE
    run_op(8'h7F, tbl[1].codes, 1, 3);
    run_op(8'hFF, tbl[4].codes, -1, 0);
    @(negedge clk);

    // Flush on digit 2 of 55
    start_valid = 1'b1; multiplier = 8'h55;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("flush_pre_idx", digit_idx, 2);
    chk("flush_pre_valid", action_valid, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_valid", action_valid, 0);
    chk("flush_done", done, 0);
    chk("flush_start_ready", start_ready, 1);
    @(negedge clk);
    chk("flush_no_done", done, 0);

    // Start coincident with flush in IDLE is ignored
    start_valid = 1'b1; flush = 1'b1; multiplier = 8'h7F;
    @(negedge clk);
    start_valid = 1'b0; flush = 1'b0;
    chk("flush_start_ignored", action_valid, 0);
    run_op(8'h80, tbl[2].codes, -1, 0);
    @(negedge clk);

    // Asynchronous reset mid-EMIT
    start_valid = 1'b1; multiplier = 8'h7F;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    run_op(8'h55, tbl[0].codes, -1, 0);
    @(negedge clk);

    // Random operands with random backpressure against the model
    for (int op = 0; op < 40; op++) begin
      logic [7:0] m;
      m  = 8'($urandom);
      ec = model(m);
      chk("rnd_start_ready", start_ready, 1);
      start_valid = 1'b1; multiplier = m; action_ready = 1'b1;
      @(negedge clk);
      start_valid = 1'b0;
      multiplier  = 8'($urandom);
      cnt = 0; cyc = 0;
      while (cnt < 4 && cyc < 200) begin
        chk("rnd_valid", action_valid, 1);
        chk("rnd_action", action, ec[cnt]);
        chk("rnd_idx", digit_idx, cnt);
        chk("rnd_last", last, (cnt == 3) ? 1 : 0);
        action_ready = ($urandom_range(0, 2) != 0);
        if (action_ready) cnt++;
        @(negedge clk);
        cyc++;
      end
      if (cnt < 4) chk("rnd_timeout", cnt, 4);
      chk("rnd_done", done, 1);
      action_ready = 1'b1;
      if ($urandom_range(0, 1) != 0) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
